// File: rtl/inst_mem_if.sv
// Fetch/load bus of the pipelined instruction memory; the memory is the slave,
// the PC/decode side is the master.
interface inst_mem_if #(
    parameter int DEPTH = 256
);
    localparam int AW = $clog2(DEPTH);

    // A fetch is accepted on a rising edge where fetch_req & fetch_ready are both high;
    // inst_valid then flags the matching result after the read latency, and the
    // master must not assume a request is taken while fetch_ready is low.
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_data;
    logic          load_ready;
    logic          fetch_req;
    logic [31:0]   fetch_addr;
    logic          fetch_ready;
    logic          stall;
    logic          inst_valid;
    logic [31:0]   inst_out;
    logic [5:0]    opcode;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic [4:0]    shamt;
    logic [5:0]    funct;
    logic [15:0]   imm;
    logic [25:0]   jump;
    logic [1:0]    fetch_fault;
    logic          state_dbg;   // 0 = CLEAR, 1 = RUN

    modport master (
        output load_en, load_addr, load_data, fetch_req, fetch_addr, stall,
        input  load_ready, fetch_ready, inst_valid, inst_out, opcode, rs, rt, rd,
               shamt, funct, imm, jump, fetch_fault, state_dbg
    );

    modport slave (
        input  load_en, load_addr, load_data, fetch_req, fetch_addr, stall,
        output load_ready, fetch_ready, inst_valid, inst_out, opcode, rs, rt, rd,
               shamt, funct, imm, jump, fetch_fault, state_dbg
    );
endinterface

// File: rtl/inst_mem_pipelined.sv
// Clocked MIPS instruction memory: clear-on-reset sequencer, program-load port,
// stallable 1- or 2-stage fetch pipeline with alignment/range fault reporting.
module inst_mem_pipelined #(
    parameter int          DEPTH    = 256,
    parameter int          READ_LAT = 1,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input logic       clk,
    input logic       reset,
    inst_mem_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
        $error("inst_mem_pipelined: READ_LAT must be 1 or 2");
    end

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] clr_idx, clr_idx_nxt;
    logic [31:0]   mem [DEPTH];

    logic          accept;
    logic [1:0]    fault_now;
    logic [AW-1:0] widx;

    logic          s1_valid;
    logic [31:0]   s1_word;
    logic [1:0]    s1_fault;

    logic          out_valid;
    logic [31:0]   out_word;
    logic [1:0]    out_fault;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else begin
            state   <= state_nxt;
            clr_idx <= clr_idx_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_idx_nxt = clr_idx;
        case (state)
            CLEAR: begin
                clr_idx_nxt = clr_idx + AW'(1);
                if (clr_idx == AW'(DEPTH - 1)) state_nxt = RUN;
            end
            RUN: state_nxt = RUN;
        endcase
    end

    assign bus.state_dbg   = (state == RUN);
    assign bus.load_ready  = (state == RUN);
    assign bus.fetch_ready = (state == RUN) && !bus.stall;
    assign accept          = bus.fetch_req && bus.fetch_ready;

    // Range uses the whole PC; only the low index bits address the array.
    assign fault_now[0] = |bus.fetch_addr[1:0];
    assign fault_now[1] = (bus.fetch_addr >> 2) >= 32'(DEPTH);
    assign widx         = bus.fetch_addr[AW+1:2];

    // Loads are blocked while the clear sequencer owns the write port.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == CLEAR) mem[clr_idx] <= NOP_WORD;
            else if (bus.load_en) mem[bus.load_addr] <= bus.load_data;
        end
    end

    // Same-edge read sees the pre-write contents, giving read-before-write on collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_word  <= NOP_WORD;
            s1_fault <= 2'b00;
        end else if (!bus.stall) begin
            s1_valid <= accept;
            if (accept) begin
                s1_fault <= fault_now;
                s1_word  <= (fault_now != 2'b00) ? NOP_WORD : mem[widx];
            end
        end
    end

    if (READ_LAT == 2) begin : g_lat2
        logic        s2_valid;
        logic [31:0] s2_word;
        logic [1:0]  s2_fault;

        always_ff @(posedge clk) begin
            if (reset) begin
                s2_valid <= 1'b0;
                s2_word  <= NOP_WORD;
                s2_fault <= 2'b00;
            end else if (!bus.stall) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_word  <= s1_word;
                    s2_fault <= s1_fault;
                end
            end
        end

        assign out_valid = s2_valid;
        assign out_word  = s2_word;
        assign out_fault = s2_fault;
    end else begin : g_lat1
        assign out_valid = s1_valid;
        assign out_word  = s1_word;
        assign out_fault = s1_fault;
    end

    assign bus.inst_valid  = out_valid;
    assign bus.inst_out    = out_word;
    assign bus.fetch_fault = out_fault;
    assign bus.opcode      = out_word[31:26];
    assign bus.rs          = out_word[25:21];
    assign bus.rt          = out_word[20:16];
    assign bus.rd          = out_word[15:11];
    assign bus.shamt       = out_word[10:6];
    assign bus.funct       = out_word[5:0];
    assign bus.imm         = out_word[15:0];
    assign bus.jump        = out_word[25:0];
endmodule
